tlu_trig_sched: RTL
===================

// Module: tlu_trig_sched
// PURPOSE
//  Trigger scheduler for the TLU master. Takes VALID and LAST_RISING_REL from N_CH input-channel receivers.
//  Forms a masked coincidence with a programmable time-window check.
//  Runs the DUT trigger handshake (REQ/ACK with timeout), then enforces a dead time.
//  Sits between the channel receivers and the trigger-output / event-number logic, all on CLK40.
// PARAMETERS
//  N_CH     6   number of input channels
//  CNT_W    32  width of TRIG_CNT (and SKIP_CNT when compiled in)
//  DEAD_W   16  width of the dead-time counter
//  TMO_W    16  width of the handshake-timeout counter
// PORTS
//  CLK40           in   1         system clock; all logic on posedge
//  RST             in   1         synchronous, active-high reset
//  EN              in   1         scheduler enable; 0 forces IDLE
//  CH_VALID        in   N_CH      per-channel VALID from the receivers
//  CH_LE_REL       in   8*N_CH    per-channel LAST_RISING_REL; ch c occupies [8c+7:8c]
//  EN_MASK         in   N_CH      channels participating in the coincidence
//  COINC_WIN       in   8         max allowed spread of rising edges, 1/16-clock units
//  DEAD_TIME       in   DEAD_W    CLK40 cycles of dead time after each trigger
//  ACK_TMO         in   TMO_W     cycles to wait for TRIG_ACK; 0 = no handshake
//  VETO            in   1         external veto; blocks new coincidences
//  TRIG_ACK        in   1         DUT acknowledge, level
//  TRIG_REQ        out  1         trigger request to DUT, held until ack/timeout
//  TRIG_PULSE      out  1         1-cycle pulse on trigger acceptance
//  TRIG_TS         out  8         oldest CH_LE_REL among masked channels at acceptance
//  TRIG_CNT        out  CNT_W     accepted-trigger count
//  BUSY            out  1         1 in FIRE/HOLD/DEAD
//  TMO_FLAG        out  1         sticky; set on ack timeout; cleared by RST or EN 1->0
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; counters 0.
//  - COINC (comb.) = (EN_MASK!=0) & ((CH_VALID & EN_MASK)==EN_MASK) & (max-min <= COINC_WIN).
//    - max/min are taken over CH_LE_REL of the masked channels.
//    - Subtraction is 8-bit unsigned; no wrap handling (receivers bound REL to <=80).
//  - States:
//    - IDLE: if EN -> WAIT.
//    - WAIT: if COINC & !VETO -> FIRE. TRIG_TS and TRIG_CNT+1 are registered on this edge.
//    - FIRE: TRIG_PULSE=1 for exactly this cycle; TRIG_REQ=1.
//      - ACK_TMO==0 -> DEAD.
//      - otherwise -> HOLD with the timeout counter loaded to ACK_TMO.
//    - HOLD: TRIG_REQ=1. Checks are in this priority order:
//      1. TRIG_ACK -> DEAD.
//      2. Counter==1 -> DEAD and TMO_FLAG<=1.
//      3. Otherwise decrement the counter.
//    - DEAD: TRIG_REQ=0; counter loaded to DEAD_TIME on entry.
//      - Exit to WAIT when the counter reaches 0.
//      - DEAD_TIME==0 gives a single DEAD cycle.
//  - Latency: COINC in cycle n -> TRIG_PULSE/TRIG_REQ high in cycle n+1.
//  - Minimum trigger spacing: 3 + DEAD_TIME cycles (ACK_TMO==0).
//  - Precedence and edge cases:
//    - EN=0 in any state -> IDLE next cycle. TRIG_REQ drops immediately (registered). TRIG_CNT is held.
//    - RST mid-handshake aborts it: TRIG_REQ=0 and all counters cleared.
//    - VETO and COINC in the same cycle: no trigger.
//    - VETO is ignored outside WAIT.
//    - TRIG_ACK already high on entry to HOLD is accepted in the first HOLD cycle.
//    - TRIG_CNT wraps at 2^CNT_W-1 -> 0.
//  - TRIG_TS is registered only on acceptance; it holds its value otherwise.
// CONFIGURATION
//  - Macro TLU_TRIG_SKIP_CNT_EN:
//    - Defined: adds output SKIP_CNT [CNT_W] (reset 0).
//      - Increments on every cycle in which COINC=1 but no trigger is taken: state != WAIT, or VETO=1.
//      - Saturates at all-ones.
//    - Undefined: the port and its counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package tlu_pkg:
//    - State encoding (IDLE=0, WAIT=1, FIRE=2, HOLD=3, DEAD=4; 3 bits).
//    - TS width constant TLU_TS_W=8.
//    - Default N_CH.
//  - Sub-module tlu_coinc_minmax (combinational):
//    - Masked min/max reduction over CH_LE_REL.
//    - Outputs MIN, MAX and ALL_VALID.
//  - State register, the two down-counters and the output registers stay in tlu_trig_sched.
// TESTING
//  1. EN_MASK=6'b000011, COINC_WIN=8, CH_LE_REL{0,1}={40,36}, both VALID 1 cycle:
//     -> TRIG_PULSE 1 cycle later, TRIG_TS=40, TRIG_CNT=1.
//  2. Same stimulus with REL={40,20}:
//     -> no TRIG_PULSE; TRIG_CNT stays 0.
//  3. ACK_TMO=10, TRIG_ACK held 0:
//     -> TRIG_REQ high 11 cycles (FIRE+10 HOLD), TMO_FLAG=1, then DEAD.
//  4. DEAD_TIME=5, ACK_TMO=0, COINC held high 20 cycles:
//     -> triggers spaced 8 cycles: 3 triggers; with TLU_TRIG_SKIP_CNT_EN, SKIP_CNT=17.
//  5. VETO=1 while COINC=1:
//     -> no trigger. Release VETO with COINC still high -> trigger next cycle.
//  6. RST asserted during HOLD:
//     -> next cycle TRIG_REQ=0, BUSY=0, TRIG_CNT=0, state IDLE.

Source files
------------

// File: rtl/tlu_pkg.sv
// ============================================================================
//  tlu_pkg
//  Shared constants and FSM state encoding for the TLU trigger scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package tlu_pkg;

    localparam int TLU_TS_W     = 8;
    localparam int TLU_N_CH_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_FIRE = 3'd2,
        ST_HOLD = 3'd3,
        ST_DEAD = 3'd4
    } tlu_state_e;

endpackage

`default_nettype wire

// File: rtl/tlu_coinc_minmax.sv
// ============================================================================
//  tlu_coinc_minmax
//  Masked min/max reduction over per-channel rising-edge times.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tlu_coinc_minmax
    import tlu_pkg::*;
#(
    parameter int N_CH = TLU_N_CH_DEF
) (
    input  logic [N_CH-1:0]          valid_i,
    input  logic [N_CH-1:0]          mask_i,
    input  logic [TLU_TS_W*N_CH-1:0] rel_i,
    output logic [TLU_TS_W-1:0]      min_o,
    output logic [TLU_TS_W-1:0]      max_o,
    output logic                     all_valid_o
);

    // Unmasked channels never move min/max away from their neutral seeds.
    always_comb begin
        min_o = '1;
        max_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (mask_i[c]) begin
                if (rel_i[c*TLU_TS_W +: TLU_TS_W] < min_o)
                    min_o = rel_i[c*TLU_TS_W +: TLU_TS_W];
                if (rel_i[c*TLU_TS_W +: TLU_TS_W] > max_o)
                    max_o = rel_i[c*TLU_TS_W +: TLU_TS_W];
            end
        end
        all_valid_o = ((valid_i & mask_i) == mask_i);
    end

endmodule

`default_nettype wire

// File: rtl/tlu_trig_sched.sv
// ============================================================================
//  tlu_trig_sched
//  Coincidence trigger scheduler: REQ/ACK handshake with timeout + dead time.
//  Optional macro: TLU_TRIG_SKIP_CNT_EN (adds saturating skip_cnt_o).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tlu_trig_sched
    import tlu_pkg::*;
#(
    parameter int N_CH   = TLU_N_CH_DEF,
    parameter int CNT_W  = 32,
    parameter int DEAD_W = 16,
    parameter int TMO_W  = 16
) (
    input  logic                     clk40_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [N_CH-1:0]          ch_valid_i,
    input  logic [TLU_TS_W*N_CH-1:0] ch_le_rel_i,
    input  logic [N_CH-1:0]          en_mask_i,
    input  logic [7:0]               coinc_win_i,
    input  logic [DEAD_W-1:0]        dead_time_i,
    input  logic [TMO_W-1:0]         ack_tmo_i,
    input  logic                     veto_i,
    input  logic                     trig_ack_i,
    output logic                     trig_req_o,
    output logic                     trig_pulse_o,
    output logic [TLU_TS_W-1:0]      trig_ts_o,
    output logic [CNT_W-1:0]         trig_cnt_o,
    output logic                     busy_o,
`ifdef TLU_TRIG_SKIP_CNT_EN
    output logic [CNT_W-1:0]         skip_cnt_o,
`endif
    output logic                     tmo_flag_o
);

    logic [TLU_TS_W-1:0] w_min;
    logic [TLU_TS_W-1:0] w_max;
    logic                w_all_valid;
    logic [TLU_TS_W-1:0] w_spread;
    logic                w_coinc;

    tlu_state_e          state_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic [DEAD_W-1:0]   dead_cnt_q;
    logic                req_q;
    logic                pulse_q;
    logic [TLU_TS_W-1:0] ts_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                flag_q;

    tlu_coinc_minmax #(.N_CH(N_CH)) u_minmax (
        .valid_i     (ch_valid_i),
        .mask_i      (en_mask_i),
        .rel_i       (ch_le_rel_i),
        .min_o       (w_min),
        .max_o       (w_max),
        .all_valid_o (w_all_valid)
    );

    // Receivers bound REL to <=80, so a plain 8-bit difference cannot wrap.
    assign w_spread = w_max - w_min;
    assign w_coinc  = (|en_mask_i) & w_all_valid & (w_spread <= coinc_win_i);

    always_ff @(posedge clk40_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tmo_cnt_q  <= '0;
            dead_cnt_q <= '0;
            req_q      <= 1'b0;
            pulse_q    <= 1'b0;
            ts_q       <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            flag_q     <= 1'b0;
        end else if (!en_i) begin
            // Disable aborts everything except the trigger count and timestamp.
            state_q    <= ST_IDLE;
            tmo_cnt_q  <= '0;
            dead_cnt_q <= '0;
            req_q      <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (w_coinc && !veto_i) begin
                        state_q <= ST_FIRE;
                        pulse_q <= 1'b1;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        ts_q    <= w_max;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FIRE: begin
                    if (ack_tmo_i == '0) begin
                        state_q    <= ST_DEAD;
                        req_q      <= 1'b0;
                        dead_cnt_q <= dead_time_i;
                    end else begin
                        state_q   <= ST_HOLD;
                        tmo_cnt_q <= ack_tmo_i;
                    end
                end
                ST_HOLD: begin
                    if (trig_ack_i || tmo_cnt_q == TMO_W'(1)) begin
                        state_q    <= ST_DEAD;
                        req_q      <= 1'b0;
                        dead_cnt_q <= dead_time_i;
                        if (!trig_ack_i)
                            flag_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt_q == '0) begin
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b0;
                    end else begin
                        dead_cnt_q <= dead_cnt_q - DEAD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TLU_TRIG_SKIP_CNT_EN
    logic [CNT_W-1:0] skip_q;

    // Counts coincidences lost to being busy/idle or vetoed; saturating.
    always_ff @(posedge clk40_i) begin
        if (rst_i)
            skip_q <= '0;
        else if (w_coinc && (state_q != ST_WAIT || veto_i) && skip_q != '1)
            skip_q <= skip_q + CNT_W'(1);
    end

    assign skip_cnt_o = skip_q;
`endif

    assign trig_req_o   = req_q;
    assign trig_pulse_o = pulse_q;
    assign trig_ts_o    = ts_q;
    assign trig_cnt_o   = cnt_q;
    assign busy_o       = busy_q;
    assign tmo_flag_o   = flag_q;

endmodule

`default_nettype wire
